// File: rtl/nioshello_key_debounce.sv
// Per-bit synchroniser + tick-paced stability-counter debouncer feeding the PIO in_port.
// Optional: NIOSHELLO_DEBOUNCE_ACTIVE_LOW_EN inverts raw inputs and resets the synchroniser to all-ones.
module nioshello_key_debounce #(
  parameter int unsigned WIDTH        = 5,
  parameter int unsigned PRESCALE     = 500,
  parameter int unsigned STABLE_TICKS = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] key_out,
  output logic [WIDTH-1:0] key_changed
);

  localparam int unsigned CNT_W = $clog2(STABLE_TICKS);
  localparam int unsigned PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_TICKS - 1);
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);

`ifdef NIOSHELLO_DEBOUNCE_ACTIVE_LOW_EN
  localparam logic [WIDTH-1:0] SYNC_IDLE = '1;
  localparam logic [WIDTH-1:0] SAMPLE_INV = '1;
`else
  localparam logic [WIDTH-1:0] SYNC_IDLE = '0;
  localparam logic [WIDTH-1:0] SAMPLE_INV = '0;
`endif

  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];
  logic [WIDTH-1:0] key_q, key_d;
  logic [WIDTH-1:0] chg_q, chg_d;
  logic             tick;
  logic [WIDTH-1:0] sample;

  // Sync flops reset to the idle input level so release never looks like a press.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= SYNC_IDLE;
      sync2_q <= SYNC_IDLE;
    end else begin
      sync1_q <= raw_in;
      sync2_q <= sync1_q;
    end
  end

  assign sample = sync2_q ^ SAMPLE_INV;
  assign tick   = (pre_q == PRE_MAX);

  // Prescaler wraps at PRESCALE-1; with PRESCALE=1 it stays at 0 and ticks every cycle.
  always_comb begin
    pre_d = pre_q + PRE_W'(1);
    if (tick) begin
      pre_d = '0;
    end
  end

  // A single agreeing tick clears the count; terminal count commits the new level.
  always_comb begin
    cnt_d = cnt_q;
    key_d = key_q;
    chg_d = '0;
    if (tick) begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        if (sample[i] == key_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CNT_MAX) begin
          cnt_d[i] = '0;
          key_d[i] = sample[i];
          chg_d[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_q <= '0;
      cnt_q <= '{default: '0};
      key_q <= '0;
      chg_q <= '0;
    end else begin
      pre_q <= pre_d;
      cnt_q <= cnt_d;
      key_q <= key_d;
      chg_q <= chg_d;
    end
  end

  assign key_out     = key_q;
  assign key_changed = chg_q;

endmodule

// File: tb/tb_nioshello_key_debounce.sv
// Bench for nioshello_key_debounce: two configurations driven by the same random keys,
// checked every cycle against a tick-window model, plus literal latency/reset checks.
module tb_nioshello_key_debounce;

  localparam int W = 5;
  localparam int PS [2] = '{1, 3};
  localparam int SS [2] = '{4, 3};

`ifdef NIOSHELLO_DEBOUNCE_ACTIVE_LOW_EN
  localparam logic [W-1:0] IDLE = '1;
`else
  localparam logic [W-1:0] IDLE = '0;
`endif

  logic         clk;
  logic         reset_n;
  logic [W-1:0] raw_in;
  logic [W-1:0] ko0, kc0, ko1, kc1;

  int checks = 0;
  int errors = 0;
  logic cmp_en = 1'b0;

  nioshello_key_debounce #(.WIDTH(W), .PRESCALE(1), .STABLE_TICKS(4)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .raw_in(raw_in), .key_out(ko0), .key_changed(kc0));

  nioshello_key_debounce #(.WIDTH(W), .PRESCALE(3), .STABLE_TICKS(3)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .raw_in(raw_in), .key_out(ko1), .key_changed(kc1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a channel flips on a tick when the last STABLE_TICKS tick samples
  // (since reset) all disagree with its current output.
  logic [W-1:0] mko [2];
  logic [W-1:0] mkc [2];
  logic [W-1:0] th [2][8];
  int           nt [2];
  int           ne;
  logic [W-1:0] rd1, rd2, smp;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ne = 0;
      rd1 = IDLE;
      rd2 = IDLE;
      for (int g = 0; g < 2; g++) begin
        mko[g] = '0;
        mkc[g] = '0;
        nt[g] = 0;
        for (int k = 0; k < 8; k++) th[g][k] = '0;
      end
    end else begin
      ne++;
      smp = rd2 ^ IDLE;
      for (int g = 0; g < 2; g++) begin
        mkc[g] = '0;
        if (ne % PS[g] == 0) begin
          for (int k = 7; k > 0; k--) th[g][k] = th[g][k-1];
          th[g][0] = smp;
          if (nt[g] < 8) nt[g]++;
          for (int i = 0; i < W; i++) begin
            logic all_diff;
            all_diff = (nt[g] >= SS[g]);
            for (int k = 0; k < SS[g]; k++)
              if (th[g][k][i] == mko[g][i]) all_diff = 1'b0;
            if (all_diff) begin
              mko[g][i] = ~mko[g][i];
              mkc[g][i] = 1'b1;
            end
          end
        end
      end
      rd2 = rd1;
      rd1 = raw_in;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("key_out cfg0", 32'(ko0), 32'(mko[0]));
      chk("key_changed cfg0", 32'(kc0), 32'(mkc[0]));
      chk("key_out cfg1", 32'(ko1), 32'(mko[1]));
      chk("key_changed cfg1", 32'(kc1), 32'(mkc[1]));
    end
  end

  initial begin
    int mode;
    int left;
    reset_n = 1'b0;
    raw_in  = IDLE;
    repeat (3) @(negedge clk);
    chk("reset key_out", 32'({ko0, ko1}), 32'(0));
    chk("reset key_changed", 32'({kc0, kc1}), 32'(0));
    cmp_en  = 1'b1;
    reset_n = 1'b1;
    raw_in  = IDLE ^ W'(1);

    // Clean rise on bit 0: cfg0 at edge 6, cfg1 at edge 9 (ticks at 3,6,9).
    for (int e = 1; e <= 10; e++) begin
      @(negedge clk);
      if (e == 5) chk("cfg0 before edge6", 32'(ko0), 32'(0));
      if (e == 6) begin
        chk("cfg0 rise edge6", 32'(ko0), 32'(1));
        chk("cfg0 pulse edge6", 32'(kc0), 32'(1));
      end
      if (e == 7) chk("cfg0 pulse single", 32'(kc0), 32'(0));
      if (e == 8) chk("cfg1 before edge9", 32'(ko1), 32'(0));
      if (e == 9) begin
        chk("cfg1 rise edge9", 32'(ko1), 32'(1));
        chk("cfg1 pulse edge9", 32'(kc1), 32'(1));
      end
      if (e == 10) chk("cfg1 pulse single", 32'(kc1), 32'(0));
    end

    // Asynchronous reset clears outputs at once; full recount afterwards.
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1 chk("async reset outputs", 32'({ko0, kc0, ko1, kc1}), 32'(0));
    @(negedge clk);
    reset_n = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      @(negedge clk);
      if (e == 5) chk("post-reset before edge6", 32'(ko0), 32'(0));
      if (e == 6) chk("post-reset rise edge6", 32'(ko0), 32'(1));
    end

    // Random bouncy / held phases with occasional resets.
    mode = 0;
    left = 0;
    for (int c = 0; c < 4000; c++) begin
      if (left == 0) begin
        mode = int'($urandom_range(0, 2));
        left = int'($urandom_range(20, 120));
      end
      left--;
      for (int i = 0; i < W; i++) begin
        case (mode)
          0: if ($urandom_range(0, 3) == 0) raw_in[i] = ~raw_in[i];
          1: if ($urandom_range(0, 39) == 0) raw_in[i] = ~raw_in[i];
          default: if ($urandom_range(0, 11) == 0) raw_in[i] = ~raw_in[i];
        endcase
      end
      if ($urandom_range(0, 799) == 0) begin
        #2 reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
      end else begin
        @(negedge clk);
      end
    end

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
